inst_fetch_ctrl: RTL and testbench

- Sequences instruction fetch from the combinational-read instruction ROM.
- Owns the PC and drives the ROM address each cycle.
- Buffers fetched words in a small queue behind a valid/ready handshake toward decode.
- Handles branch/jump redirects, and shares the ROM address port with a debug read port that is only served while fetch is halted.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 59 +++++
 rtl/inst_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_inst_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its queue.
package fetch_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, inst} entries with single-cycle flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int CNT_W  = $clog2(QDEPTH + 1),
    localparam int PTR_W  = $clog2(QDEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     r_mem [QDEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(QDEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = push && ((r_count != CNT_W'(QDEPTH)) || w_do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            // NOTE: storage is cleared so the head reads as zero straight out of reset.
            for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller: owns the PC, run/drain/halt FSM, ROM address mux and the
// debug read register; fetched words are buffered in fetch_queue toward decode.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          QDEPTH     = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_valid,
    output logic [31:0] dbg_data,
    output logic        fetch_oob
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [31:0]      r_pc;
    logic             r_dbg_valid;
    logic [31:0]      r_dbg_data;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_head;
    fetch_entry_t     w_push_entry;
    logic             w_queue_full;
    logic             w_pop;
    logic             w_push;
    logic             w_dbg_serve;

    // Any PC bit above the ROM index range means we would alias low words.
    assign fetch_oob    = (r_pc[31:ADDR_WIDTH+2] != '0);
    assign w_queue_full = (w_count == CNT_W'(QDEPTH));
    assign inst_valid   = (w_count != '0);
    assign w_pop        = inst_valid && inst_ready;
    assign w_push       = (r_state == ST_RUN) && !redirect_valid && !fetch_oob
                          && (!w_queue_full || w_pop);
    assign w_dbg_serve  = (r_state == ST_HALT) && dbg_req;
    assign rom_addr     = w_dbg_serve ? word_align(dbg_addr) : r_pc;
    assign w_push_entry = '{pc: r_pc, inst: rom_data};

    assign inst_data = w_head.inst;
    assign inst_pc   = w_head.pc;
    assign halted    = (r_state == ST_HALT);
    assign dbg_valid = r_dbg_valid;
    assign dbg_data  = r_dbg_data;

    // A redirect flushes the queue, which also throws away a same-cycle pop.
    fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop && !redirect_valid),
        .flush      (redirect_valid),
        .count      (w_count),
        .head       (w_head)
    );

    always_comb begin
        // NOTE: default first, so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN:   if (halt_req) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (!halt_req)           w_state_nxt = ST_RUN;
                else if (w_count == '0)  w_state_nxt = ST_HALT;
            end
            ST_HALT:  if (!halt_req) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) r_pc <= word_align(redirect_pc);
            else if (w_push)    r_pc <= r_pc + 32'(WORD_BYTES);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dbg_valid <= 1'b0;
            r_dbg_data  <= '0;
        end else begin
            r_dbg_valid <= w_dbg_serve;
            if (w_dbg_serve) r_dbg_data <= rom_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, mid-operation resets, and
// randomized traffic checked against a queue-based reference model.
module tb_inst_fetch_ctrl;

    localparam int          AW        = 5;
    localparam int          QD        = 2;
    localparam int          ROM_WORDS = 1 << AW;
    localparam logic [31:0] OOB_LIMIT = 32'(ROM_WORDS * 4);
    localparam int          N_RAND    = 2000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] rom_addr, rom_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req, halted;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        fetch_oob;

    logic [31:0] rom_mem [ROM_WORDS];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    assign rom_data = rom_mem[rom_addr[AW+1:2]];

    inst_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(32'h0), .QDEPTH(QD)) dut (
        .clock          (clock),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .dbg_req        (dbg_req),
        .dbg_addr       (dbg_addr),
        .dbg_valid      (dbg_valid),
        .dbg_data       (dbg_data),
        .fetch_oob      (fetch_oob)
    );

    function automatic logic [31:0] w(input int i);
        return 32'hA000_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] byte_addr);
        return rom_mem[(byte_addr >> 2) % ROM_WORDS];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        dbg_req        = 1'b0;
        dbg_addr       = '0;
    endtask

    // Called at a negedge; returns at a later negedge with reset released.
    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst.inst_valid", 32'(inst_valid), 32'h0);
        check("rst.inst_data",  inst_data,       32'h0);
        check("rst.inst_pc",    inst_pc,         32'h0);
        check("rst.halted",     32'(halted),     32'h0);
        check("rst.dbg_valid",  32'(dbg_valid),  32'h0);
        check("rst.dbg_data",   dbg_data,        32'h0);
        check("rst.rom_addr",   rom_addr,        32'h0);
        check("rst.fetch_oob",  32'(fetch_oob),  32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // ctl = {ready, redirect, halt, dbg}; ef = {valid, halted, dbg_valid, oob}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] rpc;
        logic [31:0] da;
        logic [3:0]  ef;
        logic [31:0] epc;
        logic [31:0] edat;
        logic [31:0] erom;
        logic [31:0] edd;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] rpc, da,
                                input logic [3:0] ef, input logic [31:0] epc, edat, erom, edd);
        vec_t v;
        v.ctl = ctl; v.rpc = rpc; v.da = da; v.ef = ef;
        v.epc = epc; v.edat = edat; v.erom = erom; v.edd = edd;
        return v;
    endfunction

    // Reference model: fetch queue as an SV queue, mode as a plain enum.
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef enum int { M_RUN, M_DRAIN, M_HALT } mode_e;

    ent_t        mq[$];
    mode_e       m_mode;
    logic [31:0] m_pc;
    logic        m_dbg_v;
    logic [31:0] m_dbg_d;

    task automatic model_reset();
        mq.delete();
        m_mode  = M_RUN;
        m_pc    = 32'h0;
        m_dbg_v = 1'b0;
        m_dbg_d = 32'h0;
    endtask

    task automatic model_check(input int cyc);
        logic        e_valid;
        logic [31:0] e_rom;
        e_valid = (mq.size() != 0);
        e_rom   = (m_mode == M_HALT && dbg_req) ? (dbg_addr & ~32'h3) : m_pc;
        check($sformatf("rnd%0d.inst_valid", cyc), 32'(inst_valid), 32'(e_valid));
        if (e_valid) begin
            check($sformatf("rnd%0d.inst_pc", cyc),   inst_pc,   mq[0].pc);
            check($sformatf("rnd%0d.inst_data", cyc), inst_data, mq[0].inst);
        end
        check($sformatf("rnd%0d.rom_addr", cyc),  rom_addr,       e_rom);
        check($sformatf("rnd%0d.halted", cyc),    32'(halted),    32'(m_mode == M_HALT));
        check($sformatf("rnd%0d.fetch_oob", cyc), 32'(fetch_oob), 32'(m_pc >= OOB_LIMIT));
        check($sformatf("rnd%0d.dbg_valid", cyc), 32'(dbg_valid), 32'(m_dbg_v));
        if (m_dbg_v) check($sformatf("rnd%0d.dbg_data", cyc), dbg_data, m_dbg_d);
    endtask

    task automatic model_step();
        int   sz;
        logic pop, push, oob;
        sz   = mq.size();
        pop  = (sz != 0) && inst_ready;
        oob  = (m_pc >= OOB_LIMIT);
        push = (m_mode == M_RUN) && !redirect_valid && !oob && ((sz < QD) || pop);
        m_dbg_v = (m_mode == M_HALT) && dbg_req;
        if (m_dbg_v) m_dbg_d = rom_word(dbg_addr);
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & ~32'h3;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        case (m_mode)
            M_RUN:   if (halt_req) m_mode = M_DRAIN;
            M_DRAIN: if (!halt_req) m_mode = M_RUN; else if (sz == 0) m_mode = M_HALT;
            default: if (!halt_req) m_mode = M_RUN;
        endcase
    endtask

    initial begin
        vec_t vecs[35];
        int   k;

        for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = w(i);

        // Straight-line fetch with decode always ready.
        vecs[0]  = mk(4'b1000, 0, 0, 4'b0000, 0, 0, 32'h00, 0);
        vecs[1]  = mk(4'b1000, 0, 0, 4'b1000, 32'h0, w(0), 32'h04, 0);
        vecs[2]  = mk(4'b1000, 0, 0, 4'b1000, 32'h4, w(1), 32'h08, 0);
        vecs[3]  = mk(4'b1000, 0, 0, 4'b1000, 32'h8, w(2), 32'h0C, 0);
        vecs[4]  = mk(4'b1000, 0, 0, 4'b1000, 32'hC, w(3), 32'h10, 0);
        // After a fresh reset: backpressure, redirect, halt, debug reads, out-of-range.
        vecs[5]  = mk(4'b0000, 0, 0, 4'b0000, 0, 0, 32'h00, 0);
        vecs[6]  = mk(4'b0000, 0, 0, 4'b1000, 32'h0, w(0), 32'h04, 0);
        vecs[7]  = mk(4'b0000, 0, 0, 4'b1000, 32'h0, w(0), 32'h08, 0);
        vecs[8]  = mk(4'b0000, 0, 0, 4'b1000, 32'h0, w(0), 32'h08, 0);
        vecs[9]  = mk(4'b0000, 0, 0, 4'b1000, 32'h0, w(0), 32'h08, 0);
        vecs[10] = mk(4'b1000, 0, 0, 4'b1000, 32'h0, w(0), 32'h08, 0);
        vecs[11] = mk(4'b1000, 0, 0, 4'b1000, 32'h4, w(1), 32'h0C, 0);
        vecs[12] = mk(4'b0000, 0, 0, 4'b1000, 32'h8, w(2), 32'h10, 0);
        vecs[13] = mk(4'b1100, 32'h13, 0, 4'b1000, 32'h8, w(2), 32'h10, 0);
        vecs[14] = mk(4'b1000, 0, 0, 4'b0000, 0, 0, 32'h10, 0);
        vecs[15] = mk(4'b1000, 0, 0, 4'b1000, 32'h10, w(4), 32'h14, 0);
        vecs[16] = mk(4'b0010, 0, 0, 4'b1000, 32'h14, w(5), 32'h18, 0);
        vecs[17] = mk(4'b1010, 0, 0, 4'b1000, 32'h14, w(5), 32'h1C, 0);
        vecs[18] = mk(4'b1010, 0, 0, 4'b1000, 32'h18, w(6), 32'h1C, 0);
        vecs[19] = mk(4'b1010, 0, 0, 4'b0000, 0, 0, 32'h1C, 0);
        vecs[20] = mk(4'b1011, 0, 32'hE, 4'b0100, 0, 0, 32'h0C, 0);
        vecs[21] = mk(4'b1011, 0, 32'h7, 4'b0110, 0, 0, 32'h04, w(3));
        vecs[22] = mk(4'b1010, 0, 0, 4'b0110, 0, 0, 32'h1C, w(1));
        vecs[23] = mk(4'b1010, 0, 0, 4'b0100, 0, 0, 32'h1C, 0);
        vecs[24] = mk(4'b0001, 0, 32'h8, 4'b0100, 0, 0, 32'h08, 0);
        vecs[25] = mk(4'b0001, 0, 32'h0, 4'b0010, 0, 0, 32'h1C, w(2));
        vecs[26] = mk(4'b0001, 0, 32'h0, 4'b1000, 32'h1C, w(7), 32'h20, 0);
        vecs[27] = mk(4'b1100, 32'h78, 0, 4'b1000, 32'h1C, w(7), 32'h24, 0);
        vecs[28] = mk(4'b1000, 0, 0, 4'b0000, 0, 0, 32'h78, 0);
        vecs[29] = mk(4'b1000, 0, 0, 4'b1000, 32'h78, w(30), 32'h7C, 0);
        vecs[30] = mk(4'b1000, 0, 0, 4'b1001, 32'h7C, w(31), 32'h80, 0);
        vecs[31] = mk(4'b1000, 0, 0, 4'b0001, 0, 0, 32'h80, 0);
        vecs[32] = mk(4'b1100, 32'h0, 0, 4'b0001, 0, 0, 32'h80, 0);
        vecs[33] = mk(4'b1000, 0, 0, 4'b0000, 0, 0, 32'h00, 0);
        vecs[34] = mk(4'b1000, 0, 0, 4'b1000, 32'h0, w(0), 32'h04, 0);

        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        apply_reset();

        for (int i = 0; i < 35; i++) begin
            if (i == 5) apply_reset();
            inst_ready     = vecs[i].ctl[3];
            redirect_valid = vecs[i].ctl[2];
            halt_req       = vecs[i].ctl[1];
            dbg_req        = vecs[i].ctl[0];
            redirect_pc    = vecs[i].rpc;
            dbg_addr       = vecs[i].da;
            #1;
            check($sformatf("vec%0d.inst_valid", i), 32'(inst_valid), 32'(vecs[i].ef[3]));
            if (vecs[i].ef[3]) begin
                check($sformatf("vec%0d.inst_pc", i),   inst_pc,   vecs[i].epc);
                check($sformatf("vec%0d.inst_data", i), inst_data, vecs[i].edat);
            end
            check($sformatf("vec%0d.rom_addr", i),  rom_addr,       vecs[i].erom);
            check($sformatf("vec%0d.halted", i),    32'(halted),    32'(vecs[i].ef[2]));
            check($sformatf("vec%0d.dbg_valid", i), 32'(dbg_valid), 32'(vecs[i].ef[1]));
            if (vecs[i].ef[1]) check($sformatf("vec%0d.dbg_data", i), dbg_data, vecs[i].edd);
            check($sformatf("vec%0d.fetch_oob", i), 32'(fetch_oob), 32'(vecs[i].ef[0]));
            @(negedge clock);
        end

        // Reset asserted between edges with a non-empty queue.
        idle_inputs();
        @(negedge clock);
        check("midrst.pre_valid", 32'(inst_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("midrst.inst_valid", 32'(inst_valid), 32'h0);
        check("midrst.rom_addr",   rom_addr,        32'h0);
        check("midrst.inst_pc",    inst_pc,         32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Reach HALT, then reset while a debug result is pending.
        halt_req   = 1'b1;
        inst_ready = 1'b1;
        k = 0;
        while (!halted && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("halt_wait.halted", 32'(halted), 32'h1);
        dbg_req  = 1'b1;
        dbg_addr = 32'h10;
        halt_req = 1'b0;
        @(posedge clock);
        #2;
        check("dbgrst.pre_valid", 32'(dbg_valid), 32'h1);
        check("dbgrst.pre_data",  dbg_data,       w(4));
        reset = 1'b0;
        #1;
        check("dbgrst.dbg_valid",  32'(dbg_valid),  32'h0);
        check("dbgrst.dbg_data",   dbg_data,        32'h0);
        check("dbgrst.inst_valid", 32'(inst_valid), 32'h0);
        check("dbgrst.rom_addr",   rom_addr,        32'h0);
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // Randomized traffic against the reference model.
        for (int c = 0; c < N_RAND; c++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0:       redirect_pc = $urandom;
                1, 2:    redirect_pc = 32'h70 + $urandom_range(0, 15);
                default: redirect_pc = $urandom_range(0, 127);
            endcase
            if ($urandom_range(0, 23) == 0) halt_req = ~halt_req;
            dbg_req  = ($urandom_range(0, 1) == 1);
            dbg_addr = $urandom;
            #1;
            model_check(c);
            @(posedge clock);
            model_step();
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
